interrupt_responder: RTL and testbench
======================================

// Module: interrupt_responder
// PURPOSE
// - Consumes the decoder's STI/CLI/uret strobes and external interrupt request lines.
// - Keeps the global interrupt-enable bit and latches pending requests by edge.
// - Picks the highest-priority pending request and redirects fetch to its vector.
// - Saves the resume PC and returns to it on uret. Sits beside the PC/fetch stage.
// PARAMETERS
// - N_IRQ       3             number of external request lines; index N_IRQ-1 = highest priority
// - XLEN        32            PC / address width
// - VEC_BASE    32'h0000_0100 vector address of request 0
// - VEC_STRIDE  32'h4         address step between consecutive vectors
// PORTS
// - clk          in   1      single clock; all state on its rising edge
// - rst          in   1      asynchronous, active-high reset
// - irq_in       in   N_IRQ  external request levels; rising edge = new request
// - sti          in   1      decoded STI, qualified by instruction valid: set IE
// - cli          in   1      decoded CLI, qualified: clear IE
// - uret         in   1      decoded interrupt-return, qualified
// - stall        in   1      pipeline stall; blocks interrupt entry and return
// - resume_pc    in   XLEN   PC of next instruction to execute if interrupted now
// - redirect     out  1      one-cycle pulse: fetch must load redirect_pc
// - redirect_pc  out  XLEN   vector (entry) or saved EPC (return)
// - irq_ack      out  N_IRQ  one-hot pulse, same cycle as entry redirect
// - ie           out  1      global interrupt enable
// - in_service   out  1      high from entry until return completes
// - epc          out  XLEN   saved resume PC
// BEHAVIOUR
// - Reset: all outputs 0; pending, irq_prev, epc and IE 0; FSM in IDLE. Reset mid-service drops pending requests and service state.
// - Edge capture: irq_prev <= irq_in. rise[i] = irq_in[i] & ~irq_prev[i] sets pending[i] next cycle.
//   - A held-high level is one request.
//   - A rise in the cycle pending[i] is acked leaves pending[i] set (new request wins).
// - IE update priority: entry (clear) > uret return (set) > cli (clear) > sti (set).
//   - cli and sti in the same cycle: IE cleared.
// - FSM states: IDLE, ENTER, SERVICE, RETURN.
//   - IDLE -> ENTER when ie & |pending & ~stall.
//     - Latch sel = highest set pending index and epc <= resume_pc.
//     - Clear pending[sel] and IE.
//   - ENTER (1 cycle) -> SERVICE.
//     - redirect=1, redirect_pc = VEC_BASE + sel*VEC_STRIDE (XLEN wrap), irq_ack[sel]=1.
//   - SERVICE -> RETURN on uret & ~stall. Requests keep latching. IE stays clear unless software sets it; no nesting either way.
//   - RETURN (1 cycle) -> IDLE. redirect=1, redirect_pc=epc, IE set.
//   - If pending is still set, the next entry happens no earlier than the cycle after RETURN.
// - uret in IDLE or ENTER: ignored.
// - in_service = (state != IDLE).
// - Latency: rise at edge n -> pending at n+1 -> ENTER (redirect high) during cycle n+2 when IE=1 and no stall.
// - redirect, irq_ack and redirect_pc are registered, glitch-free; redirect_pc = 0 when redirect=0.
// STRUCTURE
// - Shared package (cpu_ctrl_pkg): FSM state encoding, VEC_BASE/VEC_STRIDE defaults, XLEN.
// - One sub-module: irq_edge_capture (irq_prev, pending set/clear, ack input).
// - Top holds IE, epc, FSM, priority encoder, vector adder.
// TESTING
// - Reset, IE=0, pulse irq_in=3'b001 -> no redirect; pending[0]=1. sti -> two cycles later redirect_pc=0x100, irq_ack=001.
// - IE=1, irq_in=3'b101 same cycle, resume_pc=0x40 -> entry to 0x108, epc=0x40. After uret: redirect_pc=0x40, then entry to 0x100.
// - IE=1, stall held 5 cycles with pending[1] -> no redirect while stalled; entry to 0x104 once stall drops.
// - sti and cli same cycle -> ie=0. uret in IDLE -> no redirect, ie unchanged.
// - irq_in[2] held high 20 cycles during service -> exactly one entry; new rise in ack cycle -> second entry after return.
// - Assert rst during SERVICE -> all outputs 0 immediately (async), pending cleared, FSM IDLE.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control blocks: responder FSM encoding and
// default widths / vector layout used by interrupt_responder.
package cpu_ctrl_pkg;

   // Default datapath width and request count.
   localparam int DEF_XLEN  = 32;
   localparam int DEF_N_IRQ = 3;

   // Vector table layout: request i vectors to DEF_VEC_BASE + i*DEF_VEC_STRIDE.
   localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
   localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0004;

   // Responder FSM.
   //   ST_IDLE    : waiting for an enabled, unstalled pending request
   //   ST_ENTER   : one-cycle entry redirect to the vector
   //   ST_SERVICE : handler running, waiting for uret
   //   ST_RETURN  : one-cycle return redirect to the saved EPC
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ENTER   = 2'd1,
      ST_SERVICE = 2'd2,
      ST_RETURN  = 2'd3
   } irq_state_t;

endpackage : cpu_ctrl_pkg

// File: rtl/irq_edge_capture.sv
// Edge-triggered request latch. Each rising edge of an input line sets the
// matching pending bit; the responder clears a bit when it takes that request.
// A rise arriving in the same cycle as the clear wins, so it is never lost.
module irq_edge_capture
   import cpu_ctrl_pkg::*;
#(
   parameter int N_IRQ = DEF_N_IRQ
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] i_irq,
   input  logic [N_IRQ-1:0] i_clr,
   output logic [N_IRQ-1:0] o_pending
);

   logic [N_IRQ-1:0] r_prev;
   logic [N_IRQ-1:0] r_pending;
   logic [N_IRQ-1:0] w_rise;

   // A held-high level produces exactly one rise.
   always_comb begin
      w_rise = i_irq & ~r_prev;
   end

   // Track previous levels and update pending: clear taken bits, then OR in new rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev    <= '0;
         r_pending <= '0;
      end else begin
         r_prev    <= i_irq;
         r_pending <= (r_pending & ~i_clr) | w_rise;
      end
   end

   assign o_pending = r_pending;

endmodule : irq_edge_capture

// File: rtl/interrupt_responder.sv
// Interrupt responder beside the PC/fetch stage. Holds the global interrupt
// enable, picks the highest-priority pending request, redirects fetch to its
// vector while saving the resume PC, and redirects back to it on uret.
//
// Handshake note: there is no valid/ready pair here. sti/cli/uret are single-
// cycle strobes already qualified by instruction valid; stall is the only
// back-pressure and it holds off both entry (in IDLE) and return (in SERVICE).
// redirect is a one-cycle registered pulse that fetch must accept unconditionally.
module interrupt_responder
   import cpu_ctrl_pkg::*;
#(
   parameter int              N_IRQ      = DEF_N_IRQ,
   parameter int              XLEN       = DEF_XLEN,
   parameter logic [XLEN-1:0] VEC_BASE   = XLEN'(DEF_VEC_BASE),
   parameter logic [XLEN-1:0] VEC_STRIDE = XLEN'(DEF_VEC_STRIDE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             sti,
   input  logic             cli,
   input  logic             uret,
   input  logic             stall,
   input  logic [XLEN-1:0]  resume_pc,
   output logic             redirect,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [N_IRQ-1:0] irq_ack,
   output logic             ie,
   output logic             in_service,
   output logic [XLEN-1:0]  epc,
   output irq_state_t       o_dbg_state
);

   localparam int SEL_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   // State and registered outputs.
   irq_state_t       r_state;
   irq_state_t       w_state_nxt;
   logic             r_ie;
   logic             w_ie_nxt;
   logic [XLEN-1:0]  r_epc;
   logic [XLEN-1:0]  w_epc_nxt;
   logic             r_redirect;
   logic             w_redirect_nxt;
   logic [XLEN-1:0]  r_redirect_pc;
   logic [XLEN-1:0]  w_redirect_pc_nxt;
   logic [N_IRQ-1:0] r_irq_ack;
   logic [N_IRQ-1:0] w_irq_ack_nxt;

   // Request selection.
   logic [N_IRQ-1:0] w_pending;
   logic [N_IRQ-1:0] w_clr;
   logic [SEL_W-1:0] w_sel_idx;
   logic [N_IRQ-1:0] w_sel_onehot;
   logic [XLEN-1:0]  w_vec_addr;
   logic             w_take;
   logic             w_return;

   irq_edge_capture #(
      .N_IRQ     (N_IRQ)
   ) u_edge_capture (
      .clk       (clk),
      .rst       (rst),
      .i_irq     (irq_in),
      .i_clr     (w_clr),
      .o_pending (w_pending)
   );

   // Priority encoder: the highest set pending index wins (later iterations override).
   always_comb begin
      w_sel_idx    = '0;
      w_sel_onehot = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (w_pending[i]) begin
            w_sel_idx       = SEL_W'(i);
            w_sel_onehot    = '0;
            w_sel_onehot[i] = 1'b1;
         end
      end
   end

   // Vector address, wrapping at XLEN bits.
   always_comb begin
      w_vec_addr = VEC_BASE + (XLEN'(w_sel_idx) * VEC_STRIDE);
   end

   // Entry and return qualifiers; uret outside SERVICE is ignored.
   always_comb begin
      w_take   = (r_state == ST_IDLE) & r_ie & (|w_pending) & ~stall;
      w_return = (r_state == ST_SERVICE) & uret & ~stall;
      w_clr    = w_take ? w_sel_onehot : '0;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, next registered outputs and IE. Software sti/cli are applied
   // first so that the FSM's return (set) and entry (clear) override them.
   always_comb begin
      w_state_nxt       = r_state;
      w_redirect_nxt    = 1'b0;
      w_redirect_pc_nxt = '0;
      w_irq_ack_nxt     = '0;
      w_epc_nxt         = r_epc;
      w_ie_nxt          = r_ie;

      if (sti) begin
         w_ie_nxt = 1'b1;
      end
      if (cli) begin
         w_ie_nxt = 1'b0;
      end

      case (r_state)
         ST_IDLE: begin
            if (w_take) begin
               w_state_nxt       = ST_ENTER;
               w_redirect_nxt    = 1'b1;
               w_redirect_pc_nxt = w_vec_addr;
               w_irq_ack_nxt     = w_sel_onehot;
               w_epc_nxt         = resume_pc;
               w_ie_nxt          = 1'b0;
            end
         end
         ST_ENTER: begin
            w_state_nxt = ST_SERVICE;
         end
         ST_SERVICE: begin
            if (w_return) begin
               w_state_nxt       = ST_RETURN;
               w_redirect_nxt    = 1'b1;
               w_redirect_pc_nxt = r_epc;
               w_ie_nxt          = 1'b1;
            end
         end
         ST_RETURN: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Registered outputs, IE and EPC; reset drops everything asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ie          <= 1'b0;
         r_epc         <= '0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_irq_ack     <= '0;
      end else begin
         r_ie          <= w_ie_nxt;
         r_epc         <= w_epc_nxt;
         r_redirect    <= w_redirect_nxt;
         r_redirect_pc <= w_redirect_pc_nxt;
         r_irq_ack     <= w_irq_ack_nxt;
      end
   end

   assign redirect    = r_redirect;
   assign redirect_pc = r_redirect_pc;
   assign irq_ack     = r_irq_ack;
   assign ie          = r_ie;
   assign epc         = r_epc;
   assign in_service  = (r_state != ST_IDLE);
   assign o_dbg_state = r_state;

endmodule : interrupt_responder

// File: tb/tb_interrupt_responder.sv
// Testbench for interrupt_responder: directed scenarios with literal
// expectations plus a randomized run checked against a behavioural model and
// an expected-redirect queue.
module tb_interrupt_responder;
   import cpu_ctrl_pkg::*;

   localparam logic [31:0] TB_VEC_BASE   = 32'h100;
   localparam logic [31:0] TB_VEC_STRIDE = 32'h4;

   logic        clk;
   logic        rst;
   logic [2:0]  irq_in;
   logic        sti;
   logic        cli;
   logic        uret;
   logic        stall;
   logic [31:0] resume_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [2:0]  irq_ack;
   logic        ie;
   logic        in_service;
   logic [31:0] epc;
   irq_state_t  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: pending requests, enable, saved PC, and where we are in
   // a service episode (busy, entry pulse, return pulse).
   logic [2:0]  m_pend;
   logic [2:0]  m_prev;
   logic        m_ie;
   logic [31:0] m_epc;
   logic        m_busy;
   logic        m_entry;
   logic        m_ret;
   logic        m_redirect;
   logic [31:0] m_pc;
   logic [2:0]  m_ack;
   logic [31:0] exp_q[$];

   interrupt_responder dut (
      .clk         (clk),
      .rst         (rst),
      .irq_in      (irq_in),
      .sti         (sti),
      .cli         (cli),
      .uret        (uret),
      .stall       (stall),
      .resume_pc   (resume_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .irq_ack     (irq_ack),
      .ie          (ie),
      .in_service  (in_service),
      .epc         (epc),
      .o_dbg_state (dbg_state)
   );

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_pend = '0; m_prev = '0; m_ie = 1'b0; m_epc = '0;
      m_busy = 1'b0; m_entry = 1'b0; m_ret = 1'b0;
      m_redirect = 1'b0; m_pc = '0; m_ack = '0;
   endtask

   // Advance the model with the inputs present now, then one clock edge.
   task automatic tick();
      logic [2:0]  rise;
      logic        take;
      logic        ret;
      int          sel;
      logic [31:0] vec;
      rise = irq_in & ~m_prev;
      take = !m_busy && m_ie && (m_pend != 3'b000) && !stall;
      ret  = m_busy && !m_entry && !m_ret && uret && !stall;
      sel  = 0;
      for (int i = 0; i < 3; i++) if (m_pend[i]) sel = i;
      vec  = TB_VEC_BASE + 32'(sel) * TB_VEC_STRIDE;
      if (sti) m_ie = 1'b1;
      if (cli) m_ie = 1'b0;
      if (ret) m_ie = 1'b1;
      if (take) m_ie = 1'b0;
      m_redirect = take || ret;
      m_pc  = take ? vec : (ret ? m_epc : 32'h0);
      m_ack = take ? (3'b001 << sel) : 3'b000;
      if (ret) exp_q.push_back(m_epc);
      if (take) begin
         exp_q.push_back(vec);
         m_epc = resume_pc;
         m_pend[sel] = 1'b0;
      end
      m_pend = m_pend | rise;
      m_prev = irq_in;
      if (m_ret) m_busy = 1'b0;
      if (take) m_busy = 1'b1;
      m_entry = take;
      m_ret   = ret;
      @(posedge clk);
      #1;
   endtask

   // Stimulus only: leave SERVICE through a uret and settle back in IDLE.
   task automatic finish_service();
      tick();
      uret = 1'b1;
      tick();
      uret = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; irq_in = '0; sti = 0; cli = 0; uret = 0; stall = 0; resume_pc = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      n_checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h0 || irq_ack !== 3'b000) begin
         n_fail++; $display("FAIL reset_redirect: got %0b/%h/%b expected 0/0/000", redirect, redirect_pc, irq_ack); end
      n_checks++; if (ie !== 1'b0 || in_service !== 1'b0 || epc !== 32'h0) begin
         n_fail++; $display("FAIL reset_state: ie=%0b in_service=%0b epc=%h expected 0/0/0", ie, in_service, epc); end
      n_checks++; if (dbg_state !== ST_IDLE) begin
         n_fail++; $display("FAIL reset_fsm: got %0d expected IDLE", dbg_state); end
   endtask

   task automatic test_sw_enable();
      int seen;
      irq_in = 3'b001;
      tick();
      irq_in = 3'b000;
      seen = 0;
      repeat (3) begin tick(); if (redirect !== 1'b0) seen++; end
      n_checks++; if (seen != 0) begin
         n_fail++; $display("FAIL ie0_no_redirect: got %0d redirects expected 0", seen); end
      sti = 1'b1; resume_pc = 32'h20;
      tick();
      sti = 1'b0;
      n_checks++; if (ie !== 1'b1 || redirect !== 1'b0) begin
         n_fail++; $display("FAIL sti_set_ie: ie=%0b redirect=%0b expected 1/0", ie, redirect); end
      tick();
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h100 || irq_ack !== 3'b001) begin
         n_fail++; $display("FAIL sti_entry: got %0b/%h/%b expected 1/00000100/001", redirect, redirect_pc, irq_ack); end
      n_checks++; if (ie !== 1'b0 || in_service !== 1'b1 || epc !== 32'h20) begin
         n_fail++; $display("FAIL sti_entry_state: ie=%0b in_service=%0b epc=%h expected 0/1/20", ie, in_service, epc); end
      tick();
      uret = 1'b1;
      tick();
      uret = 1'b0;
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h20 || ie !== 1'b1) begin
         n_fail++; $display("FAIL sti_return: got %0b/%h ie=%0b expected 1/00000020 ie=1", redirect, redirect_pc, ie); end
      tick();
      n_checks++; if (in_service !== 1'b0 || redirect !== 1'b0) begin
         n_fail++; $display("FAIL sti_idle: in_service=%0b redirect=%0b expected 0/0", in_service, redirect); end
   endtask

   task automatic test_priority();
      irq_in = 3'b101; resume_pc = 32'h40;
      tick();
      n_checks++; if (redirect !== 1'b0) begin
         n_fail++; $display("FAIL prio_latency: redirect=%0b expected 0", redirect); end
      tick();
      irq_in = 3'b000;
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h108 || irq_ack !== 3'b100 || epc !== 32'h40) begin
         n_fail++; $display("FAIL prio_entry: got %0b/%h/%b epc=%h expected 1/00000108/100 epc=40", redirect, redirect_pc, irq_ack, epc); end
      tick();
      resume_pc = 32'h80; uret = 1'b1;
      tick();
      uret = 1'b0;
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h40) begin
         n_fail++; $display("FAIL prio_return: got %0b/%h expected 1/00000040", redirect, redirect_pc); end
      tick();
      n_checks++; if (redirect !== 1'b0 || in_service !== 1'b0) begin
         n_fail++; $display("FAIL prio_gap: redirect=%0b in_service=%0b expected 0/0", redirect, in_service); end
      tick();
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h100 || irq_ack !== 3'b001 || epc !== 32'h80) begin
         n_fail++; $display("FAIL prio_second: got %0b/%h/%b epc=%h expected 1/00000100/001 epc=80", redirect, redirect_pc, irq_ack, epc); end
      finish_service();
   endtask

   task automatic test_stall();
      int seen;
      stall = 1'b1; irq_in = 3'b010;
      tick();
      irq_in = 3'b000;
      seen = 0;
      repeat (5) begin tick(); if (redirect !== 1'b0) seen++; end
      n_checks++; if (seen != 0) begin
         n_fail++; $display("FAIL stall_hold: got %0d redirects expected 0", seen); end
      stall = 1'b0;
      tick();
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h104 || irq_ack !== 3'b010) begin
         n_fail++; $display("FAIL stall_entry: got %0b/%h/%b expected 1/00000104/010", redirect, redirect_pc, irq_ack); end
      finish_service();
   endtask

   task automatic test_sti_cli();
      sti = 1'b1; cli = 1'b1;
      tick();
      sti = 1'b0; cli = 1'b0;
      n_checks++; if (ie !== 1'b0) begin
         n_fail++; $display("FAIL sti_cli_same: ie=%0b expected 0", ie); end
      uret = 1'b1;
      tick();
      uret = 1'b0;
      n_checks++; if (redirect !== 1'b0 || ie !== 1'b0 || in_service !== 1'b0) begin
         n_fail++; $display("FAIL uret_idle: redirect=%0b ie=%0b in_service=%0b expected 0/0/0", redirect, ie, in_service); end
      sti = 1'b1;
      tick();
      sti = 1'b0;
      n_checks++; if (ie !== 1'b1) begin
         n_fail++; $display("FAIL sti_restore: ie=%0b expected 1", ie); end
   endtask

   task automatic test_held_level();
      int entries;
      irq_in = 3'b100;
      tick();
      tick();
      entries = (redirect === 1'b1) ? 1 : 0;
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h108) begin
         n_fail++; $display("FAIL held_entry: got %0b/%h expected 1/00000108", redirect, redirect_pc); end
      repeat (20) begin tick(); if (redirect === 1'b1) entries++; end
      uret = 1'b1;
      tick();
      uret = 1'b0;
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== epc) begin
         n_fail++; $display("FAIL held_return: got %0b/%h expected 1/%h", redirect, redirect_pc, m_pc); end
      repeat (4) begin tick(); if (redirect === 1'b1) entries++; end
      n_checks++; if (entries != 1) begin
         n_fail++; $display("FAIL held_single: got %0d entries expected 1", entries); end
      // A fresh rise in the very cycle the request is taken must survive.
      irq_in = 3'b000;
      tick();
      irq_in = 3'b100; stall = 1'b1;
      tick();
      irq_in = 3'b000;
      tick();
      irq_in = 3'b100; stall = 1'b0;
      tick();
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h108) begin
         n_fail++; $display("FAIL ackrise_entry1: got %0b/%h expected 1/00000108", redirect, redirect_pc); end
      tick();
      uret = 1'b1;
      tick();
      uret = 1'b0;
      tick();
      n_checks++; if (redirect !== 1'b0 || in_service !== 1'b0) begin
         n_fail++; $display("FAIL ackrise_gap: redirect=%0b in_service=%0b expected 0/0", redirect, in_service); end
      tick();
      n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h108 || irq_ack !== 3'b100) begin
         n_fail++; $display("FAIL ackrise_entry2: got %0b/%h/%b expected 1/00000108/100", redirect, redirect_pc, irq_ack); end
      irq_in = 3'b000;
      finish_service();
   endtask

   task automatic test_async_reset();
      int seen;
      resume_pc = 32'h1234;
      irq_in = 3'b001;
      tick();
      tick();
      irq_in = 3'b011;
      tick();
      n_checks++; if (in_service !== 1'b1 || epc !== 32'h1234) begin
         n_fail++; $display("FAIL areset_pre: in_service=%0b epc=%h expected 1/00001234", in_service, epc); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h0 || irq_ack !== 3'b000 || ie !== 1'b0 || in_service !== 1'b0 || epc !== 32'h0) begin
         n_fail++; $display("FAIL areset_outputs: %0b/%h/%b ie=%0b svc=%0b epc=%h expected all 0", redirect, redirect_pc, irq_ack, ie, in_service, epc); end
      model_reset();
      irq_in = 3'b000;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++; if (dbg_state !== ST_IDLE) begin
         n_fail++; $display("FAIL areset_fsm: got %0d expected IDLE", dbg_state); end
      sti = 1'b1;
      tick();
      sti = 1'b0;
      seen = 0;
      repeat (5) begin tick(); if (redirect !== 1'b0) seen++; end
      n_checks++; if (seen != 0 || ie !== 1'b1) begin
         n_fail++; $display("FAIL areset_pending: got %0d redirects ie=%0b expected 0 ie=1", seen, ie); end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < 3; b++) if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
         sti   = ($urandom_range(0, 9) == 0);
         cli   = ($urandom_range(0, 24) == 0);
         uret  = ($urandom_range(0, 3) == 0);
         stall = ($urandom_range(0, 4) == 0);
         resume_pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
         tick();
         n_checks++; if (redirect !== m_redirect || redirect_pc !== m_pc || irq_ack !== m_ack) begin
            n_fail++; $display("FAIL rand_redirect c=%0d: got %0b/%h/%b expected %0b/%h/%b", c, redirect, redirect_pc, irq_ack, m_redirect, m_pc, m_ack); end
         n_checks++; if (ie !== m_ie || in_service !== m_busy || epc !== m_epc) begin
            n_fail++; $display("FAIL rand_state c=%0d: got ie=%0b svc=%0b epc=%h expected %0b/%0b/%h", c, ie, in_service, epc, m_ie, m_busy, m_epc); end
         if (redirect === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rand_scoreboard c=%0d: got redirect to %h expected none", c, redirect_pc);
            end else begin
               exp_pc = exp_q.pop_front();
               if (redirect_pc !== exp_pc) begin
                  n_fail++; $display("FAIL rand_scoreboard c=%0d: got %h expected %h", c, redirect_pc, exp_pc); end
            end
         end
      end
      sti = 0; cli = 0; uret = 0; stall = 0;
      n_checks++; if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL rand_drain: %0d redirects outstanding expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_sw_enable();
      test_priority();
      test_stall();
      test_sti_cli();
      test_held_level();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_interrupt_responder
